button_debounce: RTL

Upstream conditioning stage for the button-driven LED state machine. Takes five raw, asynchronous, bouncing push-button inputs and synchronises and debounces each one. Produces a clean level, a single-cycle press pulse and an optional long-hold pulse per button. `button_press[4:0]` drives the state machine's `button[4:0]` input directly.

---
 rtl/button_debounce.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/button_debounce.sv
// button_debounce: 2-flop sync + debounce FSM per push-button channel.
// Ports: clk, reset_ (async low), button_raw[4:0] in;
//        button_level/press/release/hold[4:0] out, all registered.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 0
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic [4:0] button_raw,
    output logic [4:0] button_level,
    output logic [4:0] button_press,
    output logic [4:0] button_release,
    output logic [4:0] button_hold
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 0) ?
                        $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    for (genvar i = 0; i < 5; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        state_t        state;
        logic [CW-1:0] cnt;
        logic          level_q;
        logic          press_q;
        logic          release_q;
        logic          accept_hi;
        logic          accept_lo;

        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= button_raw[i];
                sync2 <= sync1;
            end
        end

        assign accept_hi = (state == WAIT_HIGH) && sync2 &&
                           (cnt == CNT_LAST);
        assign accept_lo = (state == WAIT_LOW) && !sync2 &&
                           (cnt == CNT_LAST);

        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) begin
                state     <= IDLE_LOW;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                unique case (state)
                    IDLE_LOW: begin
                        if (sync2) begin
                            state <= WAIT_HIGH;
                            cnt   <= CW'(1);
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        if (!sync2) begin
                            state <= IDLE_LOW;
                            cnt   <= '0;
                        end else if (accept_hi) begin
                            state   <= IDLE_HIGH;
                            cnt     <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    IDLE_HIGH: begin
                        if (!sync2) begin
                            state <= WAIT_LOW;
                            cnt   <= CW'(1);
                        end else begin
                            cnt   <= '0;
                        end
                    end
                    WAIT_LOW: begin
                        if (sync2) begin
                            state <= IDLE_HIGH;
                            cnt   <= '0;
                        end else if (accept_lo) begin
                            state     <= IDLE_LOW;
                            cnt       <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign button_level[i]   = level_q;
        assign button_press[i]   = press_q;
        assign button_release[i] = release_q;

        if (HOLD_CYCLES > 0) begin : g_hold
            localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
            localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);
            logic [HW-1:0] hcnt;
            logic          hold_q;
            logic          high_side;

            // A bounce back into IDLE_HIGH keeps counting; only an
            // accepted release (state leaves the high side) stops it.
            assign high_side = (state == IDLE_HIGH) ||
                               (state == WAIT_LOW);

            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) begin
                    hcnt   <= '0;
                    hold_q <= 1'b0;
                end else begin
                    hold_q <= 1'b0;
                    if (accept_hi) begin
                        hcnt <= '0;
                    end else if (high_side) begin
                        if (hcnt == HOLD_LAST) begin
                            hold_q <= 1'b1;
                            hcnt   <= HOLD_SAT;
                        end else if (hcnt < HOLD_LAST) begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                end
            end

            assign button_hold[i] = hold_q;
        end else begin : g_nohold
            assign button_hold[i] = 1'b0;
        end
    end

endmodule
